// File: rtl/i2c_master_contr.sv
// Single-master two-wire bus controller: START, 13-bit header, one data byte, ACK handling, STOP.
// SCL and SDA are open-drain (drive 0 or release); the read byte and ACK error are reported at done.
module i2c_master_contr #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [4:0] mem_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output wire        scl,
  inout  wire        sda
);

  localparam int unsigned QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMax = QW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QOne = QW'(1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StHdr,
    StHdrAck,
    StWdata,
    StRdata,
    StDataAck,
    StStop,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q;
  logic [1:0]    phase_q;
  logic [3:0]    bit_q;
  logic [12:0]   frame_q;
  logic [7:0]    wbyte_q;
  logic [7:0]    rshift_q;
  logic          rw_q;

  logic q_end, sample, bit_end;
  logic data_scl_low;
  logic scl_low, sda_low;
  logic sda_in;

  assign q_end        = (qcnt_q == QMax);
  assign sample       = q_end && (phase_q == 2'd1);
  assign bit_end      = q_end && (phase_q == 2'd3);
  assign data_scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);

  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = sda;

  always_comb begin
    state_d = state_q;
    scl_low = 1'b0;
    sda_low = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StStart;
      end
      StStart: begin
        busy    = 1'b1;
        scl_low = (phase_q == 2'd3);
        sda_low = phase_q[1];
        if (bit_end) state_d = StHdr;
      end
      StHdr: begin
        busy    = 1'b1;
        scl_low = data_scl_low;
        sda_low = ~frame_q[bit_q];
        if (bit_end && (bit_q == 4'd12)) state_d = StHdrAck;
      end
      StHdrAck: begin
        busy    = 1'b1;
        scl_low = data_scl_low;
        if (bit_end) begin
          if (ack_err)   state_d = StStop;
          else if (rw_q) state_d = StWdata;
          else           state_d = StRdata;
        end
      end
      StWdata: begin
        busy    = 1'b1;
        scl_low = data_scl_low;
        sda_low = ~wbyte_q[bit_q[2:0]];
        if (bit_end && (bit_q == 4'd7)) state_d = StDataAck;
      end
      StRdata: begin
        busy    = 1'b1;
        scl_low = data_scl_low;
        if (bit_end && (bit_q == 4'd7)) state_d = StDataAck;
      end
      StDataAck: begin
        // Write: slave acknowledges. Read: master leaves SDA released as the NACK.
        busy    = 1'b1;
        scl_low = data_scl_low;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        busy    = 1'b1;
        scl_low = (phase_q == 2'd0);
        sda_low = ~phase_q[1];
        if (bit_end) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      qcnt_q   <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      wbyte_q  <= '0;
      rshift_q <= '0;
      rw_q     <= 1'b0;
      rdata    <= '0;
      ack_err  <= 1'b0;
    end else begin
      state_q <= state_d;

      // The accept cycle counts as the first START clock, so done lands exactly
      // 100*CLK_DIV cycles after the cycle in which start was sampled.
      if (state_d != state_q) begin
        qcnt_q  <= (state_q == StIdle) ? QOne : '0;
        phase_q <= '0;
        bit_q   <= '0;
      end else if (busy) begin
        if (q_end) begin
          qcnt_q  <= '0;
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd3) bit_q <= bit_q + 4'd1;
        end else begin
          qcnt_q <= qcnt_q + QOne;
        end
      end

      if ((state_q == StIdle) && start) begin
        rw_q    <= rw;
        frame_q <= {dev_addr, mem_addr, rw};
        wbyte_q <= wdata;
        ack_err <= 1'b0;
      end

      if (sample) begin
        case (state_q)
          StHdrAck:  if (sda_in) ack_err <= 1'b1;
          StRdata:   rshift_q <= {sda_in, rshift_q[7:1]};
          StDataAck: if (rw_q && sda_in) ack_err <= 1'b1;
          default:   ;
        endcase
      end

      if ((state_q == StDataAck) && bit_end && !rw_q) rdata <= rshift_q;
    end
  end

endmodule

// File: tb/tb_i2c_master_contr.sv
// Scoreboard bench for i2c_master_contr: stimulus queues expected transactions, a monitor
// checks each done pulse against them; a behavioural slave ACKs and supplies read data.
module tb_i2c_master_contr;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [4:0] mem_addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_contr #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .mem_addr (mem_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl      (scl),
    .sda      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Bit order below is rise order on SCL: header, header ACK, data, data ACK, STOP rise.
  localparam logic [0:23] W_BITS = 24'b1101000101010_0_10100101_0_0;
  localparam logic [0:23] R_BITS = 24'b0111110101010_0_00111100_1_0;
  localparam logic [0:23] N_BITS = 24'b1101000101010_1_0_000000000;

  typedef struct {
    int          acc;
    int          lat;
    int          nbits;
    logic [0:23] bits;
    logic [7:0]  rdata;
    logic        aerr;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input int lat, input int nb, input logic [0:23] bits,
                              input logic [7:0] rd, input logic ae);
    exp_t e;
    e.acc   = 0;
    e.lat   = lat;
    e.nbits = nb;
    e.bits  = bits;
    e.rdata = rd;
    e.aerr  = ae;
    return e;
  endfunction

  // Behavioural slave and bus recorder.
  logic       last_scl = 1'b1;
  logic       last_sda = 1'b1;
  logic       bus_bits[$];
  logic       stop_seen = 1'b0;
  logic       ack_hdr = 1'b1;
  logic [7:0] slave_rbyte = 8'h3C;
  int         n_rise;
  logic       rd_txn;

  always @(scl or sda) begin
    if (scl === 1'b1 && last_scl !== 1'b1) begin
      bus_bits.push_back((sda === 1'b0) ? 1'b0 : 1'b1);
    end else if (scl === 1'b0 && last_scl === 1'b1) begin
      n_rise = bus_bits.size();
      rd_txn = (n_rise > 0) && (bus_bits[0] == 1'b0);
      if (n_rise == 13)                         slave_low = ack_hdr;
      else if (n_rise >= 14 && n_rise <= 21 && rd_txn)
                                                slave_low = ~slave_rbyte[n_rise-14];
      else if (n_rise == 22 && !rd_txn)         slave_low = ack_hdr;
      else                                      slave_low = 1'b0;
    end else if (scl === 1'b1 && last_scl === 1'b1) begin
      if (last_sda === 1'b1 && sda === 1'b0) begin
        bus_bits.delete();
        stop_seen = 1'b0;
        slave_low = 1'b0;
      end else if (last_sda === 1'b0 && sda === 1'b1) begin
        stop_seen = 1'b1;
      end
    end
    last_scl = scl;
    last_sda = sda;
  end

  // Monitor: compares every done pulse against the head of the scoreboard.
  int          busy_cnt = 0;
  int          first_busy = -1;
  exp_t        cur;
  logic [0:23] act_bits;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt   = 0;
      first_busy = -1;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur      = exp_q.pop_front();
          act_bits = '0;
          for (int i = 0; i < bus_bits.size() && i < 24; i++) act_bits[i] = bus_bits[i];
          check("latency", cyc - cur.acc, cur.lat);
          check("busy_at_done", {31'd0, busy}, 32'd0);
          check("busy_cycles", busy_cnt, cur.lat - 1);
          check("busy_rise", first_busy - cur.acc, 32'd1);
          check("rdata", {24'd0, rdata}, {24'd0, cur.rdata});
          check("ack_err", {31'd0, ack_err}, {31'd0, cur.aerr});
          check("scl_rises", bus_bits.size(), cur.nbits);
          check("sda_bits", {8'd0, act_bits}, {8'd0, cur.bits});
          check("stop_seen", {31'd0, stop_seen}, 32'd1);
        end
        busy_cnt   = 0;
        first_busy = -1;
      end
    end
  end

  task automatic issue(input logic [6:0] d, input logic [4:0] m, input logic r,
                       input logic [7:0] w, input exp_t e, input bit push, input bit keep,
                       output int acc);
    exp_t ev;
    @(negedge clk);
    dev_addr = d;
    mem_addr = m;
    rw       = r;
    wdata    = w;
    start    = 1'b1;
    acc      = cyc;
    ev       = e;
    ev.acc   = acc;
    if (push) exp_q.push_back(ev);
    if (!keep) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int acc;
  exp_t e2;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_scl", {31'd0, scl === 1'b1}, 32'd1);
    check("rst_sda", {31'd0, sda === 1'b1}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write, both ACKed.
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(400, 24, W_BITS, 8'h00, 1'b0), 1'b1, 1'b0, acc);
    wait_drain(1000);

    // Read returning 0x3C.
    issue(7'h2A, 5'h1F, 1'b0, 8'h00, mk(400, 24, R_BITS, 8'h3C, 1'b0), 1'b1, 1'b0, acc);
    wait_drain(1000);

    // start while busy is ignored; latched command survives input changes.
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(400, 24, W_BITS, 8'h3C, 1'b0), 1'b1, 1'b0, acc);
    wait_cyc(acc + 10);
    start    = 1'b1;
    wdata    = 8'hFF;
    dev_addr = 7'h7F;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(acc + 200);
    start = 1'b1;
    rw    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(1000);
    repeat (40) @(negedge clk);

    // Header NACK.
    ack_hdr = 1'b0;
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(256, 15, N_BITS, 8'h3C, 1'b1), 1'b1, 1'b0, acc);
    wait_drain(1000);
    ack_hdr = 1'b1;
    repeat (5) @(negedge clk);
    check("ack_err_hold", {31'd0, ack_err}, 32'd1);

    // Reset mid-transaction.
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(400, 24, W_BITS, 8'h00, 1'b0), 1'b0, 1'b0, acc);
    wait_cyc(acc + 150);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_scl", {31'd0, scl === 1'b1}, 32'd1);
    check("abort_sda", {31'd0, sda === 1'b1}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    check("abort_ack_err", {31'd0, ack_err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // New command after the abort.
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(400, 24, W_BITS, 8'h00, 1'b0), 1'b1, 1'b0, acc);
    wait_drain(1000);

    // Back-to-back with start held: write then read, 401 cycles apart.
    issue(7'h2A, 5'h05, 1'b1, 8'hA5, mk(400, 24, W_BITS, 8'h00, 1'b0), 1'b1, 1'b1, acc);
    e2     = mk(400, 24, R_BITS, 8'h3C, 1'b0);
    e2.acc = acc + 401;
    exp_q.push_back(e2);
    repeat (5) @(negedge clk);
    rw       = 1'b0;
    mem_addr = 5'h1F;
    wdata    = 8'h00;
    wait_cyc(acc + 801);
    start = 1'b0;
    wait_drain(1000);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
